// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register file write port between NUM_REQ
// writeback requesters, and sequences a full register-file clear to zero.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          stall,
  input  logic                          clear_req,
  output logic                          writeEnable,
  output logic [ADDR_WIDTH-1:0]         dst,
  output logic [DATA_WIDTH-1:0]         dstWrite,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          clear_busy,
  output logic                          clear_done,
  output logic [15:0]                   conflict_count
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]   clear_addr_q, clear_addr_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [GW-1:0]           grant_id_q, grant_id_d;
  logic                    clear_busy_q, clear_busy_d;
  logic                    clear_done_q, clear_done_d;
  logic [15:0]             conflict_q, conflict_d;

  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
  logic                    grant_valid;
  logic [GW-1:0]           grant_idx;
  logic [GW:0]             probe;
  logic                    multi_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign multi_valid = ($countones(req_valid) > 1);

  // Search upward from rr_ptr with wrap-around; the first valid hit wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (probe >= (GW+1)'(NUM_REQ)) begin
        probe = probe - (GW+1)'(NUM_REQ);
      end
      if (!grant_valid && req_valid[probe[GW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = probe[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    clear_addr_d = clear_addr_q;
    we_d         = 1'b0;
    dst_d        = dst_q;
    wdata_d      = wdata_q;
    grant_id_d   = grant_id_q;
    clear_busy_d = clear_busy_q;
    clear_done_d = 1'b0;
    conflict_d   = conflict_q;
    req_ready    = '0;

    case (state_q)
      ST_ARB: begin
        if (multi_valid && (conflict_q != 16'hFFFF)) begin
          conflict_d = conflict_q + 16'd1;
        end
        if (!stall) begin
          if (clear_req) begin
            state_d      = ST_CLEAR;
            clear_addr_d = '0;
            clear_busy_d = 1'b1;
          end else if (grant_valid && rst_n) begin
            req_ready[grant_idx] = 1'b1;
            we_d       = 1'b1;
            dst_d      = addr_arr[grant_idx];
            wdata_d    = data_arr[grant_idx];
            grant_id_d = grant_idx;
            rr_ptr_d   = (grant_idx == GW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        we_d         = 1'b1;
        dst_d        = clear_addr_q;
        wdata_d      = '0;
        clear_addr_d = clear_addr_q + 1'b1;
        if (clear_addr_q == '1) begin
          state_d      = ST_ARB;
          clear_busy_d = 1'b0;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      clear_addr_q <= '0;
      we_q         <= 1'b0;
      dst_q        <= '0;
      wdata_q      <= '0;
      grant_id_q   <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
      conflict_q   <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      clear_addr_q <= clear_addr_d;
      we_q         <= we_d;
      dst_q        <= dst_d;
      wdata_q      <= wdata_d;
      grant_id_q   <= grant_id_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
      conflict_q   <= conflict_d;
    end
  end

  assign writeEnable    = we_q;
  assign dst            = dst_q;
  assign dstWrite       = wdata_q;
  assign grant_id       = grant_id_q;
  assign clear_busy     = clear_busy_q;
  assign clear_done     = clear_done_q;
  assign conflict_count = conflict_q;

endmodule
